// File: rtl/snn_sched_pkg.sv
// ---------------------------------------------------------------------------
// snn_sched_pkg
//   Shared types and default sizes for the spike event scheduler.
//   - sched_state_t : scheduler FSM states
//   - DEF_*         : default parameter values for spk_event_sched
//   - max_int()     : elaboration-time helper for sizing the wait counter
// ---------------------------------------------------------------------------
package snn_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACC_WAIT  = 2'd1,
      LEAK_WAIT = 2'd2
   } sched_state_t;

   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_ADDR_W       = 5;
   localparam int DEF_ACTIV_CYCLES = 6;
   localparam int DEF_LEAK_CYCLES  = 6;
   localparam int DEF_CNT_W        = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spk_event_sched_fifo.sv
// ---------------------------------------------------------------------------
// spk_addr_fifo
//   Synchronous FIFO holding pre-synaptic spike addresses.
//   Push and pop in the same cycle are legal, including when full: the pop
//   frees the slot the push writes into, and the occupancy stays constant.
//   Ports:
//     clk, rst   clock / asynchronous active-low reset
//     push, wdata write request and data (ignored when full without a pop)
//     pop, rdata  read request; rdata shows the head entry combinationally
//     count       current occupancy (0..DEPTH)
//     full, empty occupancy flags
// ---------------------------------------------------------------------------
module spk_addr_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 5
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_FULL);
   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is only accepted when the same cycle pops.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define
   // which entries are valid, so clearing the data would only add fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spk_event_sched.sv
// ---------------------------------------------------------------------------
// spk_event_sched
//   Upstream sequencer for one layer of neural units. Spike addresses are
//   buffered in a FIFO; each one is issued as a single activ_en pulse with
//   shift_phase held for the full accumulate window. At a timestep boundary
//   (step_end) and once all earlier spikes are drained, one layer_activ pulse
//   starts the bias/leak/threshold pass. All outputs are registered.
//   Ports:
//     clk, rst     clock / asynchronous active-low reset
//     spk_valid    upstream spike address valid
//     spk_addr     pre-synaptic spike address
//     spk_ready    FIFO accepts (transfer on spk_valid & spk_ready)
//     step_end     single-cycle timestep-boundary strobe
//     shift_phase  address of the spike in service
//     activ_en     1-cycle accumulate start pulse
//     layer_activ  1-cycle activation start pulse
//     busy         FSM active, FIFO non-empty or step pending
//     spk_cnt      activ_en pulses issued in the current timestep (saturating)
// ---------------------------------------------------------------------------
module spk_event_sched
   import snn_sched_pkg::*;
#(
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int ACTIV_CYCLES = DEF_ACTIV_CYCLES,
   parameter int LEAK_CYCLES  = DEF_LEAK_CYCLES,
   parameter int CNT_W        = DEF_CNT_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              spk_valid,
   input  logic [ADDR_W-1:0] spk_addr,
   output logic              spk_ready,
   input  logic              step_end,
   output logic [ADDR_W-1:0] shift_phase,
   output logic              activ_en,
   output logic              layer_activ,
   output logic              busy,
   output logic [CNT_W-1:0]  spk_cnt
);

   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int WAIT_W = $clog2(max_int(ACTIV_CYCLES, LEAK_CYCLES));
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
   // The pulse cycle is spent in IDLE, so each wait state covers N-1 cycles
   // and the counter's last value is N-2.
   localparam logic [WAIT_W-1:0] ACC_LAST  = WAIT_W'(ACTIV_CYCLES - 2);
   localparam logic [WAIT_W-1:0] LEAK_LAST = WAIT_W'(LEAK_CYCLES - 2);

   sched_state_t      state, state_next;
   logic [WAIT_W-1:0] wcnt, wcnt_next;
   logic              step_pend, step_pend_next;
   logic [CNT_W-1:0]  spk_cnt_next;
   logic [ADDR_W-1:0] shift_phase_next;
   logic              activ_en_next;
   logic              layer_activ_next;
   logic              spk_ready_next;
   logic              busy_next;

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] fifo_rdata;
   logic [FCNT_W-1:0] fifo_count;
   logic [FCNT_W-1:0] count_next;
   logic              fifo_full;
   logic              fifo_empty;

   spk_addr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (spk_addr),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign push       = spk_valid & spk_ready & (~fifo_full | pop);
   assign count_next = fifo_count + FCNT_W'(push) - FCNT_W'(pop);

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_next       = state;
      wcnt_next        = wcnt;
      step_pend_next   = step_pend | step_end;
      spk_cnt_next     = spk_cnt;
      shift_phase_next = shift_phase;
      activ_en_next    = 1'b0;
      layer_activ_next = 1'b0;
      pop              = 1'b0;

      case (state)
         IDLE: begin
            wcnt_next = '0;
            // Spikes of the current step always go before the pending leak.
            if (!fifo_empty) begin
               pop              = 1'b1;
               shift_phase_next = fifo_rdata;
               activ_en_next    = 1'b1;
               if (spk_cnt != {CNT_W{1'b1}}) spk_cnt_next = spk_cnt + 1'b1;
               state_next       = ACC_WAIT;
            end else if (step_pend) begin
               layer_activ_next = 1'b1;
               state_next       = LEAK_WAIT;
            end
         end
         ACC_WAIT: begin
            if (wcnt == ACC_LAST) begin
               wcnt_next  = '0;
               state_next = IDLE;
            end else begin
               wcnt_next  = wcnt + 1'b1;
            end
         end
         LEAK_WAIT: begin
            if (wcnt == LEAK_LAST) begin
               wcnt_next      = '0;
               step_pend_next = 1'b0;
               spk_cnt_next   = '0;
               state_next     = IDLE;
            end else begin
               wcnt_next      = wcnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // A full FIFO may still accept when the next cycle is IDLE: IDLE pops
      // the head in that same cycle, which keeps push+pop-while-full usable.
      spk_ready_next = ~step_pend_next &
                       ((count_next != FIFO_FULL) | (state_next == IDLE));
      busy_next      = (state_next != IDLE) | (count_next != '0) | step_pend_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wcnt        <= '0;
         step_pend   <= 1'b0;
         spk_cnt     <= '0;
         shift_phase <= '0;
         activ_en    <= 1'b0;
         layer_activ <= 1'b0;
         spk_ready   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_next;
         wcnt        <= wcnt_next;
         step_pend   <= step_pend_next;
         spk_cnt     <= spk_cnt_next;
         shift_phase <= shift_phase_next;
         activ_en    <= activ_en_next;
         layer_activ <= layer_activ_next;
         spk_ready   <= spk_ready_next;
         busy        <= busy_next;
      end
   end

endmodule

// File: tb/tb_spk_event_sched.sv
// ---------------------------------------------------------------------------
// tb_spk_event_sched
//   Directed bench for spk_event_sched. Accepted spike addresses are pushed
//   to a scoreboard queue; a negedge monitor pops one entry per activ_en and
//   compares shift_phase, checks that shift_phase only changes on activ_en,
//   and timestamps every activ_en / layer_activ pulse for gap checks.
// ---------------------------------------------------------------------------
module tb_spk_event_sched;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int ACT_N  = 6;
   localparam int LEAK_N = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              spk_valid = 1'b0;
   logic [ADDR_W-1:0] spk_addr = '0;
   logic              step_end = 1'b0;
   logic              spk_ready;
   logic [ADDR_W-1:0] shift_phase;
   logic              activ_en;
   logic              layer_activ;
   logic              busy;
   logic [CNT_W-1:0]  spk_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   logic [ADDR_W-1:0] sb[$];
   int act_t[$];
   int leak_t[$];
   logic [ADDR_W-1:0] prev_phase = '0;

   spk_event_sched #(
      .FIFO_DEPTH   (DEPTH),
      .ADDR_W       (ADDR_W),
      .ACTIV_CYCLES (ACT_N),
      .LEAK_CYCLES  (LEAK_N),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spk_valid   (spk_valid),
      .spk_addr    (spk_addr),
      .spk_ready   (spk_ready),
      .step_end    (step_end),
      .shift_phase (shift_phase),
      .activ_en    (activ_en),
      .layer_activ (layer_activ),
      .busy        (busy),
      .spk_cnt     (spk_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Stimulus acts 2 time units after the falling edge, after the monitor.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   // Present one spike and hold it until accepted; spk_ready is a register,
   // so its value now decides the transfer at the coming rising edge.
   task automatic send(input logic [ADDR_W-1:0] a, input string tag);
      bit ok = 1'b0;
      spk_valid = 1'b1;
      spk_addr  = a;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (spk_ready) begin
            sb.push_back(a);
            ok = 1'b1;
         end
         tick();
      end
      spk_valid = 1'b0;
      check({tag, "_accept"}, 32'(ok), 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 0);
   endtask

   task automatic wait_act(input int target, input int budget, input string tag);
      int n = 0;
      while (act_t.size() < target && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_act_seen"}, 32'(act_t.size() >= target), 1);
   endtask

   task automatic wait_leak(input int target, input int budget, input string tag);
      int n = 0;
      while (leak_t.size() < target && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_leak_seen"}, 32'(leak_t.size() >= target), 1);
   endtask

   // Output monitor: scoreboard pop on activ_en, phase stability otherwise.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         prev_phase = shift_phase;
      end else begin
         if (activ_en) begin
            act_t.push_back(cyc);
            check("excl_pulse", 32'(layer_activ), 0);
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check("shift_phase", 32'(shift_phase), 32'(sb.pop_front()));
         end else begin
            check("phase_hold", 32'(shift_phase), 32'(prev_phase));
         end
         if (layer_activ) leak_t.push_back(cyc);
         prev_phase = shift_phase;
      end
   end

   initial begin
      int base_a;
      int base_l;
      int pushed;
      int n;
      bit saw_full;
      logic [ADDR_W-1:0] nxt;

      // ---------------- reset state ----------------
      tick(2);
      check("rst_ready",  32'(spk_ready), 0);
      check("rst_activ",  32'(activ_en), 0);
      check("rst_layer",  32'(layer_activ), 0);
      check("rst_busy",   32'(busy), 0);
      check("rst_cnt",    32'(spk_cnt), 0);
      check("rst_phase",  32'(shift_phase), 0);
      rst = 1'b1;
      tick();
      check("post_rst_ready", 32'(spk_ready), 1);
      check("post_rst_busy",  32'(busy), 0);

      // ---------------- back-to-back spikes 3, 7, 12 ----------------
      base_a = act_t.size();
      send(5'd3,  "t2a");
      send(5'd7,  "t2b");
      send(5'd12, "t2c");
      wait_idle("t2", 60);
      check("t2_n_act", 32'(act_t.size() - base_a), 3);
      if (act_t.size() >= base_a + 3) begin
         check("t2_gap1", 32'(act_t[base_a+1] - act_t[base_a]), ACT_N);
         check("t2_gap2", 32'(act_t[base_a+2] - act_t[base_a+1]), ACT_N);
      end
      check("t2_spk_cnt", 32'(spk_cnt), 3);
      check("t2_phase_kept", 32'(shift_phase), 12);

      // ---------------- reset in the middle of ACC_WAIT ----------------
      base_a = act_t.size();
      send(5'd5, "t1a");
      send(5'd9, "t1b");
      wait_act(base_a + 1, 20, "t1");
      tick(2);
      rst = 1'b0;
      #1;
      check("t1_ready", 32'(spk_ready), 0);
      check("t1_busy",  32'(busy), 0);
      check("t1_activ", 32'(activ_en), 0);
      check("t1_layer", 32'(layer_activ), 0);
      check("t1_phase", 32'(shift_phase), 0);
      check("t1_cnt",   32'(spk_cnt), 0);
      sb.delete();
      tick();
      rst = 1'b1;
      tick(12);
      check("t1_no_more_act", 32'(act_t.size() - base_a), 1);
      check("t1_busy_after",  32'(busy), 0);
      check("t1_ready_after", 32'(spk_ready), 1);

      // ---------------- fill to full, then push+pop while full ----------------
      pushed   = 0;
      saw_full = 1'b0;
      nxt      = 5'd1;
      spk_valid = 1'b1;
      spk_addr  = nxt;
      for (int c = 0; c < 200 && !saw_full; c++) begin
         if (spk_ready) begin
            sb.push_back(spk_addr);
            pushed++;
            tick();
            nxt      = nxt + 5'd7;
            spk_addr = nxt;
         end else begin
            saw_full = 1'b1;
         end
      end
      check("t3_saw_full",   32'(saw_full), 1);
      check("t3_full_count", 32'(sb.size()), DEPTH);
      n = 0;
      while (!spk_ready && n < 20) begin
         tick();
         n++;
      end
      check("t3_ready_again",    32'(spk_ready), 1);
      check("t3_count_before_pp", 32'(sb.size()), DEPTH);
      sb.push_back(spk_addr);
      pushed++;
      tick();
      spk_valid = 1'b0;
      check("t3_count_after_pp", 32'(sb.size()), DEPTH);
      check("t3_ready_after_pp", 32'(spk_ready), 0);
      wait_idle("t3", 200);
      check("t3_drained", 32'(sb.size()), 0);
      check("t3_spk_cnt", 32'(spk_cnt), 32'(pushed));

      // ---------------- step_end with two spikes queued ----------------
      base_a = act_t.size();
      base_l = leak_t.size();
      send(5'd17, "t4a");
      send(5'd22, "t4b");
      step_end = 1'b1;
      tick();
      step_end = 1'b0;
      check("t4_ready_pend", 32'(spk_ready), 0);
      wait_leak(base_l + 1, 40, "t4");
      check("t4_n_act", 32'(act_t.size() - base_a), 2);
      if (leak_t.size() > base_l && act_t.size() > base_a)
         check("t4_leak_gap", 32'(leak_t[$] - act_t[$]), ACT_N);
      check("t4_cnt_in_leak", 32'(spk_cnt), 32'(pushed + 2));
      wait_idle("t4", 20);
      check("t4_cnt_cleared", 32'(spk_cnt), 0);
      check("t4_ready_after", 32'(spk_ready), 1);

      // ---------------- empty step, doubled strobe ----------------
      base_l = leak_t.size();
      step_end = 1'b1;
      tick();
      step_end = 1'b0;
      check("t5_ready_pend", 32'(spk_ready), 0);
      tick();
      step_end = 1'b1;
      tick();
      step_end = 1'b0;
      n = 0;
      while (!spk_ready && n < 30) begin
         tick();
         n++;
      end
      check("t5_one_leak", 32'(leak_t.size() - base_l), 1);
      if (leak_t.size() > base_l)
         check("t5_ready_delay", 32'(cyc - leak_t[$]), LEAK_N - 1);
      tick(10);
      check("t5_still_one_leak", 32'(leak_t.size() - base_l), 1);
      check("t5_busy", 32'(busy), 0);

      // ---------------- spike held across a pending step ----------------
      base_a = act_t.size();
      base_l = leak_t.size();
      step_end = 1'b1;
      tick();
      step_end = 1'b0;
      spk_valid = 1'b1;
      spk_addr  = 5'd21;
      check("t6_ready_pend", 32'(spk_ready), 0);
      check("t6_busy",       32'(busy), 1);
      n = 0;
      while (!spk_ready && n < 30) begin
         tick();
         n++;
      end
      check("t6_leak_first", 32'(leak_t.size() - base_l), 1);
      sb.push_back(5'd21);
      tick();
      spk_valid = 1'b0;
      wait_idle("t6", 30);
      check("t6_n_act",   32'(act_t.size() - base_a), 1);
      check("t6_spk_cnt", 32'(spk_cnt), 1);
      if (act_t.size() > base_a && leak_t.size() > base_l)
         check("t6_act_after_leak", 32'(act_t[$] > leak_t[$]), 1);

      check("final_sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
